fifo_read_ctrl: RTL and testbench
=================================

// Module: fifo_read_ctrl
// PURPOSE
// - Read-side drain controller, directly downstream of async_fifo, in the read clock domain.
// - Pops words from the FIFO at a paced rate: a programmable number of idle cycles between reads.
// - Holds each word in an output register and presents it on a valid/ready interface to the consumer.
// - Counts delivered words and flags the end of each burst.
// PARAMETERS
// - DATA_WIDTH   8    width of FIFO word and m_data
// - IDLE_CYCLES  2    idle cycles between end of one transfer and next read; 0 = back-to-back
// - BURST_LEN    120  words per burst; burst_done pulses after the last one
// PORTS
// - clk         in   1           read-domain clock; all logic on posedge
// - rst_n       in   1           asynchronous, active-low reset
// - enable      in   1           1 = draining allowed; sampled only in IDLE
// - fifo_data   in   DATA_WIDTH  FIFO data_out; valid the cycle after fifo_read=1
// - fifo_empty  in   1           FIFO empty flag, already synchronised to clk
// - fifo_read   out  1           one-cycle pop strobe to FIFO read
// - m_data      out  DATA_WIDTH  output word
// - m_valid     out  1           m_data valid
// - m_ready     in   1           consumer accepts when m_valid&&m_ready at posedge
// - burst_done  out  1           one-cycle pulse on acceptance of word BURST_LEN of a burst
// - busy        out  1           1 whenever state != IDLE
// BEHAVIOUR
// - Reset (async, rst_n=0): state=IDLE; fifo_read, m_valid, burst_done, busy=0; m_data=0; counters=0.
// - FSM, one state per cycle unless noted:
// -   IDLE: if enable && !fifo_empty -> RD; else stay.
// -   RD: fifo_read=1 for exactly this cycle -> CAP.
// -   CAP: m_data<=fifo_data, m_valid<=1 -> HOLD.
// -   HOLD: m_valid=1, m_data stable; on m_ready: m_valid<=0, beat_cnt++ -> GAP (IDLE if IDLE_CYCLES==0).
// -   GAP: gap_cnt counts 1..IDLE_CYCLES, then -> IDLE with gap_cnt cleared.
// - Latency: fifo_empty falling in IDLE -> fifo_read 1 cycle later -> m_valid 2 cycles after fifo_read rises.
// - Min period per word = 4 + IDLE_CYCLES cycles (IDLE, RD, CAP, HOLD with m_ready=1, GAP).
// - fifo_read is never asserted while fifo_empty=1 at the same posedge; no pop without an empty check.
// - At most one word in flight; no new read issued until the held word is accepted.
// - Valid/ready: once m_valid=1, m_data and m_valid hold until accepted; m_ready ignored when m_valid=0.
// - beat_cnt width $clog2(BURST_LEN+1).
//   - On accepting word BURST_LEN: burst_done=1 next cycle for 1 cycle; beat_cnt wraps to 0.
// - enable deasserted outside IDLE: current transfer completes (incl. GAP), then FSM parks in IDLE.
// - fifo_empty rising during CAP/HOLD/GAP: no effect on the word in flight.
// - Reset mid-transfer: held word is discarded, counters cleared; FIFO sees no extra fifo_read.
// CONFIGURATION
// - FIFO_READ_CTRL_STATS_EN defined:
//   - Adds output rd_total [31:0]: total words accepted since reset; saturates at 32'hFFFF_FFFF.
//   - Adds output stall_cycles [15:0]: cycles in HOLD with m_ready=0; saturating; both reset to 0.
// - Not defined: neither port exists, no counter logic is built; all other behaviour is identical.
// TESTING
// - Reset with fifo_empty=0, enable=1: all outputs 0 while rst_n=0; first fifo_read 1 cycle after rst_n rises.
// - IDLE_CYCLES=2, m_ready=1, FIFO preloaded 0x11,0x22,0x33: m_data 0x11,0x22,0x33; fifo_read rises every 6 cycles.
// - m_ready held 0 for 10 cycles while m_data=0xA5: m_valid and 0xA5 stable; fifo_read stays 0; accepted on release.
// - Empty corner: fifo_empty=1, enable=1: fifo_read never asserts; FIFO holds one word: exactly one fifo_read pulse.
// - BURST_LEN=4, 9 words, m_ready=1: burst_done pulses after words 4 and 8 only; beat_cnt=1 at end.
// - rst_n pulsed low during HOLD: m_valid drops immediately; after reset the next word re-reads; with STATS_EN, rd_total=0.

Source files
------------

// File: rtl/fifo_read_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_read_ctrl
//
// Read-side drain controller for an async FIFO, living in the read clock
// domain. Pops one word at a time at a paced rate, holds it in an output
// register and offers it to a consumer on a valid/ready interface. Counts
// delivered words and pulses burst_done after every BURST_LEN-th word.
//
// Parameters
//   DATA_WIDTH   width of the FIFO word and m_data
//   IDLE_CYCLES  idle (GAP) cycles after each accepted word; 0 = none
//   BURST_LEN    words per burst
//
// Ports
//   clk            read-domain clock, all logic on posedge
//   rst_n          asynchronous active-low reset
//   enable         draining allowed; only looked at in IDLE
//   fifo_data      FIFO read data, valid the cycle after fifo_read
//   fifo_empty     FIFO empty flag, already in the clk domain
//   fifo_read      one-cycle pop strobe
//   m_data         output word
//   m_valid        m_data valid
//   m_ready        consumer ready
//   burst_done     one-cycle pulse after the last word of a burst is accepted
//   busy           FSM is not in IDLE
//   rd_total       (FIFO_READ_CTRL_STATS_EN only) words accepted, saturating
//   stall_cycles   (FIFO_READ_CTRL_STATS_EN only) HOLD cycles with m_ready=0,
//                  saturating
//   dbg_state_o    current FSM state encoding (IDLE=0,RD=1,CAP=2,HOLD=3,GAP=4)
//   dbg_beat_cnt_o words accepted in the current burst
//
// Optional feature macro: FIFO_READ_CTRL_STATS_EN
//
// Handshake: a word transfers on a posedge where m_valid && m_ready. Once
// m_valid is 1, m_valid and m_data stay unchanged until that transfer;
// m_ready is ignored while m_valid is 0. At most one word is ever in flight.
// ---------------------------------------------------------------------------
module fifo_read_ctrl #(
    parameter int DATA_WIDTH  = 8,
    parameter int IDLE_CYCLES = 2,
    parameter int BURST_LEN   = 120
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            enable,
    input  logic [DATA_WIDTH-1:0]           fifo_data,
    input  logic                            fifo_empty,
    output logic                            fifo_read,
    output logic [DATA_WIDTH-1:0]           m_data,
    output logic                            m_valid,
    input  logic                            m_ready,
    output logic                            burst_done,
    output logic                            busy,
`ifdef FIFO_READ_CTRL_STATS_EN
    output logic [31:0]                     rd_total,
    output logic [15:0]                     stall_cycles,
`endif
    output logic [2:0]                      dbg_state_o,
    output logic [$clog2(BURST_LEN+1)-1:0]  dbg_beat_cnt_o
);

    localparam int BEAT_W = $clog2(BURST_LEN + 1);
    localparam int GAP_W  = (IDLE_CYCLES > 0) ? $clog2(IDLE_CYCLES + 1) : 1;

    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((IDLE_CYCLES > 0) ? IDLE_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_CAP  = 3'd2,
        S_HOLD = 3'd3,
        S_GAP  = 3'd4
    } state_e;

    state_e                  state_q;
    logic [GAP_W-1:0]        gap_cnt_q;
    logic [BEAT_W-1:0]       beat_cnt_q;
    logic                    fifo_read_q;
    logic [DATA_WIDTH-1:0]   m_data_q;
    logic                    m_valid_q;
    logic                    burst_done_q;
    logic                    busy_q;

    // Word handed to the consumer at the coming posedge.
    logic hold_accept;
    assign hold_accept = (state_q == S_HOLD) && m_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            gap_cnt_q    <= '0;
            beat_cnt_q   <= '0;
            fifo_read_q  <= 1'b0;
            m_data_q     <= '0;
            m_valid_q    <= 1'b0;
            burst_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            burst_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // The empty check happens here, so the pop strobe in RD
                    // is always backed by a word.
                    if (enable && !fifo_empty) begin
                        state_q     <= S_RD;
                        fifo_read_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                S_RD: begin
                    fifo_read_q <= 1'b0;
                    state_q     <= S_CAP;
                end
                S_CAP: begin
                    m_data_q  <= fifo_data;
                    m_valid_q <= 1'b1;
                    state_q   <= S_HOLD;
                end
                S_HOLD: begin
                    if (hold_accept) begin
                        m_valid_q <= 1'b0;
                        if (beat_cnt_q == BEAT_LAST) begin
                            beat_cnt_q   <= '0;
                            burst_done_q <= 1'b1;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + 1'b1;
                        end
                        if (IDLE_CYCLES == 0) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt_q == GAP_LAST) begin
                        gap_cnt_q <= '0;
                        state_q   <= S_IDLE;
                        busy_q    <= 1'b0;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    fifo_read_q <= 1'b0;
                    m_valid_q   <= 1'b0;
                    busy_q      <= 1'b0;
                    gap_cnt_q   <= '0;
                end
            endcase
        end
    end

    assign fifo_read      = fifo_read_q;
    assign m_data         = m_data_q;
    assign m_valid        = m_valid_q;
    assign burst_done     = burst_done_q;
    assign busy           = busy_q;
    assign dbg_state_o    = state_q;
    assign dbg_beat_cnt_o = beat_cnt_q;

`ifdef FIFO_READ_CTRL_STATS_EN
    logic [31:0] rd_total_q, rd_total_d;
    logic [15:0] stall_q, stall_d;

    always_comb begin
        rd_total_d = rd_total_q;
        stall_d    = stall_q;
        if (hold_accept && (rd_total_q != 32'hFFFF_FFFF)) begin
            rd_total_d = rd_total_q + 32'd1;
        end
        if ((state_q == S_HOLD) && !m_ready && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_total_q <= '0;
            stall_q    <= '0;
        end else begin
            rd_total_q <= rd_total_d;
            stall_q    <= stall_d;
        end
    end

    assign rd_total     = rd_total_q;
    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fifo_read_ctrl
//
// Directed bench for fifo_read_ctrl (DATA_WIDTH=8, IDLE_CYCLES=2,
// BURST_LEN=4). A small FIFO model feeds the DUT; every word pushed into it
// is also pushed into exp_q, and a negedge monitor pops and compares each
// word the DUT hands over, alongside handshake and burst_done checks.
// ---------------------------------------------------------------------------
module tb_fifo_read_ctrl;

    localparam int DW = 8;
    localparam int IC = 2;
    localparam int BL = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic          enable = 1'b0;
    logic [DW-1:0] fifo_data = '0;
    logic          fifo_empty;
    logic          fifo_read;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic          burst_done;
    logic          busy;
    logic [2:0]    dbg_state;
    logic [2:0]    dbg_beat_cnt;
`ifdef FIFO_READ_CTRL_STATS_EN
    logic [31:0]   rd_total;
    logic [15:0]   stall_cycles;
`endif

    fifo_read_ctrl #(
        .DATA_WIDTH (DW),
        .IDLE_CYCLES(IC),
        .BURST_LEN  (BL)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .fifo_data     (fifo_data),
        .fifo_empty    (fifo_empty),
        .fifo_read     (fifo_read),
        .m_data        (m_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .burst_done    (burst_done),
        .busy          (busy),
`ifdef FIFO_READ_CTRL_STATS_EN
        .rd_total      (rd_total),
        .stall_cycles  (stall_cycles),
`endif
        .dbg_state_o   (dbg_state),
        .dbg_beat_cnt_o(dbg_beat_cnt)
    );

    // ---------------- bookkeeping ----------------
    int errors = 0;
    int checks = 0;
    logic [DW-1:0] exp_q[$];
    int rise_q[$];          // cycle numbers of each fifo_read pop
    int cyc = 0;
    int bd_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---------------- FIFO model ----------------
    logic [DW-1:0] mem [0:63];
    int push_n = 0;         // written by stimulus only
    int pop_n  = 0;         // written by the model only
    assign fifo_empty = (push_n == pop_n);

    always @(posedge clk) begin
        cyc++;
        if (fifo_read) begin
            rise_q.push_back(cyc);
            checks++;
            if (push_n == pop_n) begin
                errors++;
                $display("FAIL pop_on_empty: fifo_read=1 with fifo_empty=1 (t=%0t)", $time);
            end else begin
                fifo_data = mem[pop_n];
                pop_n++;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic          prev_valid = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_acc = 1'b0;
    logic          bd_pend = 1'b0;
    int            acc_n = 0;

    always @(negedge clk) begin
        logic acc;
        if (!rst_n) begin
            prev_valid = 1'b0;
            prev_acc   = 1'b0;
            bd_pend    = 1'b0;
            acc_n      = 0;
        end else begin
            check("burst_done", {31'd0, burst_done}, {31'd0, bd_pend});
            if (burst_done) bd_count++;
            if (prev_valid && !prev_acc) begin
                check("hold_valid", {31'd0, m_valid}, 32'd1);
                check("hold_data", {24'd0, m_data}, {24'd0, prev_data});
            end
            if (m_valid) check("no_read_in_flight", {31'd0, fifo_read}, 32'd0);
            acc = m_valid && m_ready;
            bd_pend = 1'b0;
            if (acc) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL m_data: unexpected word 0x%0h, expected none", m_data);
                end else begin
                    check("m_data", {24'd0, m_data}, {24'd0, exp_q.pop_front()});
                end
                acc_n++;
                if (acc_n % BL == 0) bd_pend = 1'b1;
            end
            prev_valid = m_valid;
            prev_data  = m_data;
            prev_acc   = acc;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] d);
        mem[push_n] = d;
        push_n++;
        exp_q.push_back(d);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            step(1);
            n++;
        end
        check(name, exp_q.size(), 32'd0);
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!m_valid && n < 50) begin
            step(1);
            n++;
        end
        check(name, {31'd0, m_valid}, 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Reset with a non-empty FIFO and enable high.
        rst_n   = 1'b0;
        enable  = 1'b1;
        m_ready = 1'b1;
        push(8'h11);
        push(8'h22);
        push(8'h33);
        step(2);
        check("rst_fifo_read", {31'd0, fifo_read}, 32'd0);
        check("rst_m_valid", {31'd0, m_valid}, 32'd0);
        check("rst_m_data", {24'd0, m_data}, 32'd0);
        check("rst_burst_done", {31'd0, burst_done}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_state", {29'd0, dbg_state}, 32'd0);
        rst_n = 1'b1;
        step(1);
        check("first_read", {31'd0, fifo_read}, 32'd1);
        check("busy_after_read", {31'd0, busy}, 32'd1);

        // Paced drain of three words: one pop every 4+IDLE_CYCLES = 6 cycles.
        wait_drain("drain_three");
        check("pop_count_3", rise_q.size(), 32'd3);
        check("period_1", rise_q[1] - rise_q[0], 32'd6);
        check("period_2", rise_q[2] - rise_q[1], 32'd6);

        // Consumer stall: 0xA5 held for 10 cycles, 0x5A waits in the FIFO.
        m_ready = 1'b0;
        push(8'hA5);
        push(8'h5A);
        wait_valid("a5_valid");
        check("a5_data", {24'd0, m_data}, 32'h0000_00A5);
        step(10);
        check("stall_valid", {31'd0, m_valid}, 32'd1);
        check("stall_data", {24'd0, m_data}, 32'h0000_00A5);
        check("no_read_while_held", rise_q.size(), 32'd4);
        m_ready = 1'b1;
        wait_drain("drain_stall");

        // Empty FIFO: no pops at all, then exactly one for a single word.
        step(8);
        check("pops_before_idle", rise_q.size(), 32'd5);
        step(20);
        check("no_pop_when_empty", rise_q.size(), 32'd5);
        push(8'h77);
        wait_drain("drain_single");
        step(8);
        check("single_pop", rise_q.size(), 32'd6);

        // Reset while a word is held: it is dropped, the next word is read.
        m_ready = 1'b0;
        push(8'hC3);
        push(8'h3C);
        wait_valid("c3_valid");
        check("c3_data", {24'd0, m_data}, 32'h0000_00C3);
        rst_n = 1'b0;
        #1;
        check("rst_drops_valid", {31'd0, m_valid}, 32'd0);
        check("rst_drops_busy", {31'd0, busy}, 32'd0);
        check("rst_drops_read", {31'd0, fifo_read}, 32'd0);
        void'(exp_q.pop_front());
`ifdef FIFO_READ_CTRL_STATS_EN
        check("rst_rd_total", rd_total, 32'd0);
        check("rst_stall_cycles", {16'd0, stall_cycles}, 32'd0);
`endif
        step(2);
        rst_n   = 1'b1;
        m_ready = 1'b1;
        wait_drain("drain_after_reset");
        step(8);
        check("pops_after_reset", rise_q.size(), 32'd8);

        // Burst of nine words with BURST_LEN=4: pulses after words 4 and 8.
        begin
            int bd0;
            rst_n = 1'b0;
            step(2);
            rst_n = 1'b1;
            bd0 = bd_count;
            for (int i = 0; i < 9; i++) push(8'h40 + 8'(i));
            wait_drain("drain_burst");
            step(8);
            check("burst_pulses", bd_count - bd0, 32'd2);
            check("beat_cnt_end", {29'd0, dbg_beat_cnt}, 32'd1);
`ifdef FIFO_READ_CTRL_STATS_EN
            check("rd_total_end", rd_total, 32'd9);
            check("stall_cycles_end", {16'd0, stall_cycles}, 32'd0);
`endif
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Last-resort guard; every wait above is already bounded.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
